mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline latch and writeback-select stage of the pipelined MIPS datapath.
- Captures the instruction leaving MEM and selects the write-back value from ALU result, load data, link PC or LUI immediate.
- Drives the register file write port (WEN/wsel/wdat). The register file commits on negedge CLK, so ID reads the new value in the same cycle (split-phase).
- Also owns the sticky halt flag and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- CLK  input  1  clock; WB latch updates on posedge
- nRST  input  1  reset, asynchronous, active-low
- stall  input  1  hold WB latch contents
- flush  input  1  load bubble into WB latch
- mem_valid  input  1  MEM stage holds a real instruction
- mem_regwen  input  1  instruction writes a register
- mem_wsel  input  5  destination register
- mem_wbsrc  input  2  00 ALU, 01 load, 10 link (npc), 11 LUI
- mem_aluout  input  32  ALU result
- mem_dmemload  input  32  data memory load word
- mem_npc  input  32  PC+4 for JAL
- mem_imm16  input  16  immediate for LUI
- mem_halt  input  1  instruction is HALT
- rf_WEN  output  1  register file write enable
- rf_wsel  output  5  register file write select
- rf_wdat  output  32  register file write data
- wb_valid  output  1  WB latch holds a real instruction
- halt  output  1  sticky halt to system
- retired  output  CNT_W  count of retired instructions

Behaviour:
- Reset (async, nRST=0): WB latch cleared, giving wb_valid=0, rf_WEN=0, rf_wsel=0, rf_wdat=0. halt=0, retired=0. Reset mid-operation drops the in-flight instruction with no write.
- Latch update at posedge, in priority order:
  - halt=1: latch loads a bubble (all fields 0).
  - flush=1: latch loads a bubble. flush wins over stall.
  - stall=1: latch holds all fields.
  - Otherwise: latch captures all mem_* fields; wb_valid <= mem_valid.
- wdat is computed combinationally from latched fields:
  - ALU: aluout
  - load: dmemload
  - link: npc
  - LUI: {imm16, 16'h0000}
- rf_wdat is the selected value, or 0 when wb_valid=0.
- rf_wsel = latched wsel.
- rf_WEN = wb_valid & regwen & (wsel != 0) & ~halt. A write to $0 is never issued.
- Stall with a valid write in WB: rf_WEN stays 1 every stalled cycle, rewriting the same value, which is idempotent.
- Halt:
  - halt is set at the posedge after which WB holds a valid HALT (wb_valid & latched halt bit). In practice halt goes 1 one cycle after HALT enters WB.
  - halt stays 1 until reset.
  - HALT itself has regwen=0 and writes nothing.
- retired:
  - Increments by 1 at each posedge where wb_valid=1, stall=0 and halt=0. A HALT in WB is counted.
  - A stalled instruction is counted once, on the cycle it leaves.
  - Wraps modulo 2^CNT_W.
- Latency: MEM to register write is 1 cycle (captured at posedge N, written at negedge N).

Optional Feature:
- Macro: MEM_WB_FWD_HIST_EN.
- Defined: adds outputs fwd_hist_valid (1), fwd_hist_sel (5), fwd_hist_dat (32).
  - These form a one-entry history of the last committed write, registered at posedge whenever rf_WEN=1 and stall=0.
  - Reset to 0. Cleared when halt is set.
  - Feeds the EX forwarding unit for 3-apart dependencies without relying on split-phase timing.
- Undefined: ports and history registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-write: valid ALU write to $5 in WB, pulse nRST low between edges -> rf_WEN=0, wb_valid=0, retired=0 immediately; $5 not written.
- ALU and LUI select: mem_wbsrc=00, aluout=0x0000_1234, wsel=8 -> next cycle rf_WEN=1, rf_wsel=8, rf_wdat=0x0000_1234. Then wbsrc=11, imm16=0xBEEF -> rf_wdat=0xBEEF_0000.
- Load and link: wbsrc=01, dmemload=0xCAFE_F00D, wsel=9 -> wdat=0xCAFE_F00D. wbsrc=10, npc=0x0000_0044, wsel=31 -> wdat=0x44, wsel=31.
- $0 suppression: regwen=1, wsel=0, aluout=0xFFFF_FFFF -> rf_WEN=0; retired still increments.
- Stall/flush: valid write held with stall=1 for 3 cycles -> latch held, retired +1 only on release. stall=1 and flush=1 together -> bubble, wb_valid=0.
- Halt: HALT entering WB after 4 valid instructions -> halt=1 the following cycle, retired=5 and frozen; later valid writes never assert rf_WEN.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline latch, write-back select, sticky halt and retired-instruction counter.
// Optional macro MEM_WB_FWD_HIST_EN adds a one-entry history of the last committed write.
module mem_wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_regwen,
  input  logic [4:0]       mem_wsel,
  input  logic [1:0]       mem_wbsrc,
  input  logic [31:0]      mem_aluout,
  input  logic [31:0]      mem_dmemload,
  input  logic [31:0]      mem_npc,
  input  logic [15:0]      mem_imm16,
  input  logic             mem_halt,
  output logic             rf_WEN,
  output logic [4:0]       rf_wsel,
  output logic [31:0]      rf_wdat,
  output logic             wb_valid,
  output logic             halt,
`ifdef MEM_WB_FWD_HIST_EN
  output logic             fwd_hist_valid,
  output logic [4:0]       fwd_hist_sel,
  output logic [31:0]      fwd_hist_dat,
`endif
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_LUI  = 2'b11
  } wbsrc_t;

  typedef struct packed {
    logic        valid;
    logic        regwen;
    logic [4:0]  wsel;
    wbsrc_t      wbsrc;
    logic [31:0] aluout;
    logic [31:0] dmemload;
    logic [31:0] npc;
    logic [15:0] imm16;
    logic        halt;
  } wb_t;

  wb_t         wb;
  wb_t         mem_in;
  logic [31:0] wdat_sel;
  logic        halt_set;

  assign mem_in = '{
    valid:    mem_valid,
    regwen:   mem_regwen,
    wsel:     mem_wsel,
    wbsrc:    wbsrc_t'(mem_wbsrc),
    aluout:   mem_aluout,
    dmemload: mem_dmemload,
    npc:      mem_npc,
    imm16:    mem_imm16,
    halt:     mem_halt
  };

  // A valid HALT sitting in WB raises the sticky flag at the next edge.
  assign halt_set = wb.valid & wb.halt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      wb      <= '0;
      halt    <= 1'b0;
      retired <= '0;
    end else begin
      if (halt || flush)
        wb <= '0;
      else if (!stall)
        wb <= mem_in;

      if (halt_set)
        halt <= 1'b1;

      // A stalled instruction is counted only on the edge it leaves WB.
      if (wb.valid && !stall && !halt)
        retired <= retired + CNT_W'(1);
    end
  end

  // NOTE: the default assignment before the case keeps this block latch-free.
  always_comb begin
    wdat_sel = wb.aluout;
    unique case (wb.wbsrc)
      WB_ALU:  wdat_sel = wb.aluout;
      WB_LOAD: wdat_sel = wb.dmemload;
      WB_LINK: wdat_sel = wb.npc;
      WB_LUI:  wdat_sel = {wb.imm16, 16'h0000};
    endcase
  end

  assign wb_valid = wb.valid;
  assign rf_wsel  = wb.wsel;
  assign rf_wdat  = wb.valid ? wdat_sel : 32'h0000_0000;
  // $0 is hard-wired, so a write to it is never issued.
  assign rf_WEN   = wb.valid & wb.regwen & (wb.wsel != 5'd0) & ~halt;

`ifdef MEM_WB_FWD_HIST_EN
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      fwd_hist_valid <= 1'b0;
      fwd_hist_sel   <= '0;
      fwd_hist_dat   <= '0;
    end else if (halt_set) begin
      fwd_hist_valid <= 1'b0;
      fwd_hist_sel   <= '0;
      fwd_hist_dat   <= '0;
    end else if (rf_WEN && !stall) begin
      fwd_hist_valid <= 1'b1;
      fwd_hist_sel   <= rf_wsel;
      fwd_hist_dat   <= rf_wdat;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised self-checking bench for mem_wb_stage against a transaction-level model.
module tb_mem_wb_stage;

  localparam int CNT_W = 32;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        stall, flush;
  logic        mem_valid, mem_regwen, mem_halt;
  logic [4:0]  mem_wsel;
  logic [1:0]  mem_wbsrc;
  logic [31:0] mem_aluout, mem_dmemload, mem_npc;
  logic [15:0] mem_imm16;
  logic        rf_WEN, wb_valid, halt;
  logic [4:0]  rf_wsel;
  logic [31:0] rf_wdat;
  logic [CNT_W-1:0] retired;
`ifdef MEM_WB_FWD_HIST_EN
  logic        fwd_hist_valid;
  logic [4:0]  fwd_hist_sel;
  logic [31:0] fwd_hist_dat;
`endif

  mem_wb_stage #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_regwen(mem_regwen), .mem_wsel(mem_wsel),
    .mem_wbsrc(mem_wbsrc), .mem_aluout(mem_aluout), .mem_dmemload(mem_dmemload),
    .mem_npc(mem_npc), .mem_imm16(mem_imm16), .mem_halt(mem_halt),
    .rf_WEN(rf_WEN), .rf_wsel(rf_wsel), .rf_wdat(rf_wdat),
    .wb_valid(wb_valid), .halt(halt),
`ifdef MEM_WB_FWD_HIST_EN
    .fwd_hist_valid(fwd_hist_valid), .fwd_hist_sel(fwd_hist_sel),
    .fwd_hist_dat(fwd_hist_dat),
`endif
    .retired(retired)
  );

  always #5 CLK = ~CLK;

  // Register file model, committing on negedge like the real one.
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(negedge CLK) if (rf_WEN) rf[rf_wsel] <= rf_wdat;

  typedef struct {
    bit        valid;
    bit        regwen;
    bit [4:0]  wsel;
    bit [1:0]  wbsrc;
    bit [31:0] alu;
    bit [31:0] load;
    bit [31:0] npc;
    bit [15:0] imm;
    bit        halt;
  } txn_t;

  // Model state: what instruction WB holds, halt flag, retire count.
  txn_t      m_wb;
  bit        m_halt;
  bit [31:0] m_ret;
  bit        m_hv;
  bit [4:0]  m_hs;
  bit [31:0] m_hd;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic txn_t bubble();
    txn_t t;
    t = '{default: 0};
    return t;
  endfunction

  function automatic txn_t mk(bit v, bit rw, bit [4:0] ws, bit [1:0] src,
                              bit [31:0] alu, bit [31:0] ld, bit [31:0] npc,
                              bit [15:0] imm, bit h);
    txn_t t;
    t.valid = v; t.regwen = rw; t.wsel = ws; t.wbsrc = src;
    t.alu = alu; t.load = ld; t.npc = npc; t.imm = imm; t.halt = h;
    return t;
  endfunction

  function automatic bit [31:0] exp_wdat();
    if (!m_wb.valid) return 32'h0;
    case (m_wb.wbsrc)
      2'd0:    return m_wb.alu;
      2'd1:    return m_wb.load;
      2'd2:    return m_wb.npc;
      default: return {16'h0, m_wb.imm} << 16;
    endcase
  endfunction

  function automatic bit exp_wen();
    return m_wb.valid && m_wb.regwen && (m_wb.wsel != 0) && !m_halt;
  endfunction

  task automatic model_reset();
    m_wb = bubble(); m_halt = 0; m_ret = 0;
    m_hv = 0; m_hs = 0; m_hd = 0;
  endtask

  task automatic model_edge(input txn_t t, input bit st, input bit fl);
    bit hs;
    hs = m_wb.valid && m_wb.halt;
    if (hs) begin
      m_hv = 0; m_hs = 0; m_hd = 0;
    end else if (exp_wen() && !st) begin
      m_hv = 1; m_hs = m_wb.wsel; m_hd = exp_wdat();
    end
    if (m_wb.valid && !st && !m_halt) m_ret = m_ret + 1;
    if (m_halt || fl)  m_wb = bubble();
    else if (!st)      m_wb = t;
    if (hs) m_halt = 1;
  endtask

  task automatic check_all();
    check("wb_valid", 32'(wb_valid), 32'(m_wb.valid));
    check("rf_WEN",   32'(rf_WEN),   32'(exp_wen()));
    check("rf_wsel",  32'(rf_wsel),  32'(m_wb.wsel));
    check("rf_wdat",  rf_wdat,       exp_wdat());
    check("halt",     32'(halt),     32'(m_halt));
    check("retired",  retired,       m_ret);
`ifdef MEM_WB_FWD_HIST_EN
    check("hist_valid", 32'(fwd_hist_valid), 32'(m_hv));
    check("hist_sel",   32'(fwd_hist_sel),   32'(m_hs));
    check("hist_dat",   fwd_hist_dat,        m_hd);
`endif
  endtask

  task automatic apply(input txn_t t, input bit st, input bit fl);
    mem_valid = t.valid; mem_regwen = t.regwen; mem_wsel = t.wsel;
    mem_wbsrc = t.wbsrc; mem_aluout = t.alu; mem_dmemload = t.load;
    mem_npc = t.npc; mem_imm16 = t.imm; mem_halt = t.halt;
    stall = st; flush = fl;
  endtask

  task automatic step(input txn_t t, input bit st, input bit fl);
    @(negedge CLK);
    apply(t, st, fl);
    @(posedge CLK);
    model_edge(t, st, fl);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic pulse_reset();
    #1 nRST = 1'b0;
    #1;
    model_reset();
    check_all();
    nRST = 1'b1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.valid  = bit'($urandom_range(0, 3) != 0);
    t.halt   = t.valid && ($urandom_range(0, 63) == 0);
    t.regwen = !t.halt && bit'($urandom_range(0, 1));
    t.wsel   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    t.wbsrc  = 2'($urandom);
    t.alu    = $urandom;
    t.load   = $urandom;
    t.npc    = $urandom;
    t.imm    = 16'($urandom);
    return t;
  endfunction

  initial begin
    bit [31:0] r0;
    int halted_for;
    nRST = 1'b0;
    apply(bubble(), 1'b0, 1'b0);
    model_reset();
    #12;
    check("reset_wen",  32'(rf_WEN),  32'h0);
    check("reset_wdat", rf_wdat,      32'h0);
    check_all();
    nRST = 1'b1;

    // ALU then LUI select
    step(mk(1, 1, 5'd8, 2'b00, 32'h0000_1234, 0, 0, 0, 0), 0, 0);
    check("alu_wen",  32'(rf_WEN),  32'h1);
    check("alu_wsel", 32'(rf_wsel), 32'd8);
    check("alu_wdat", rf_wdat,      32'h0000_1234);
    step(mk(1, 1, 5'd8, 2'b11, 32'h1111_1111, 0, 0, 16'hBEEF, 0), 0, 0);
    check("lui_wdat", rf_wdat, 32'hBEEF_0000);

    // Load and link select
    step(mk(1, 1, 5'd9, 2'b01, 32'h1, 32'hCAFE_F00D, 32'h2, 16'h3, 0), 0, 0);
    check("load_wdat", rf_wdat, 32'hCAFE_F00D);
    step(mk(1, 1, 5'd31, 2'b10, 32'h1, 32'h2, 32'h0000_0044, 16'h3, 0), 0, 0);
    check("link_wdat", rf_wdat, 32'h0000_0044);
    check("link_wsel", 32'(rf_wsel), 32'd31);

    // $0 suppression; still retires
    step(mk(1, 1, 5'd0, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, 0), 0, 0);
    check("zero_wen", 32'(rf_WEN), 32'h0);
    r0 = m_ret;
    step(bubble(), 0, 0);
    check("zero_retired", retired, r0 + 1);

    // Stall holds a valid write for three cycles
    step(mk(1, 1, 5'd10, 2'b00, 32'h0000_00A5, 0, 0, 0, 0), 0, 0);
    r0 = m_ret;
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 1, 5'd11, 2'b01, 32'h0, 32'h5A5A_5A5A, 0, 0, 0), 1, 0);
      check("stall_wen",  32'(rf_WEN),  32'h1);
      check("stall_wsel", 32'(rf_wsel), 32'd10);
      check("stall_wdat", rf_wdat,      32'h0000_00A5);
      check("stall_ret",  retired,      r0);
    end
    step(bubble(), 0, 0);
    check("stall_release_ret", retired, r0 + 1);

    // Flush wins over stall
    step(mk(1, 1, 5'd12, 2'b00, 32'h77, 0, 0, 0, 0), 0, 0);
    step(mk(1, 1, 5'd13, 2'b00, 32'h88, 0, 0, 0, 0), 1, 1);
    check("flush_valid", 32'(wb_valid), 32'h0);

    // Reset mid-write: $5 must never be written
    step(mk(1, 1, 5'd5, 2'b00, 32'hDEAD_BEEF, 0, 0, 0, 0), 0, 0);
    pulse_reset();
    check("rst_wen",     32'(rf_WEN),   32'h0);
    check("rst_valid",   32'(wb_valid), 32'h0);
    check("rst_retired", retired,       32'h0);
    step(bubble(), 0, 0);
    check("rst_rf5", rf[5], 32'h0);

    // Halt after four valid instructions
    pulse_reset();
    for (int i = 0; i < 4; i++)
      step(mk(1, 1, 5'(i + 1), 2'b00, 32'(i * 3 + 1), 0, 0, 0, 0), 0, 0);
    step(mk(1, 0, 5'd0, 2'b00, 0, 0, 0, 0, 1), 0, 0);
    check("halt_not_yet", 32'(halt), 32'h0);
    step(bubble(), 0, 0);
    check("halt_set",     32'(halt), 32'h1);
    check("halt_retired", retired,   32'd5);
    for (int i = 0; i < 3; i++) begin
      step(mk(1, 1, 5'd20, 2'b00, 32'h1234_5678, 0, 0, 0, 0), 0, 0);
      check("halt_wen",     32'(rf_WEN), 32'h0);
      check("halt_frozen",  retired,     32'd5);
      check("halt_sticky",  32'(halt),   32'h1);
    end
    pulse_reset();

    // Randomised traffic, resetting a few cycles after each halt
    halted_for = 0;
    for (int i = 0; i < 2000; i++) begin
      step(rand_txn(), bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 7) == 0));
      if (m_halt) halted_for++;
      if (halted_for > 3) begin
        pulse_reset();
        halted_for = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
